control_unit: RTL and testbench

Hardwired Moore control sequencer for the Mini-SRC CPU. It sits directly upstream of the datapath and drives every datapath control input from IR, CON and a stop request. The sequence is: fetch (T0–T2), decode, then per-class execute steps (T3–T7), then back to fetch.

---
 rtl/control_unit.sv | 243 ++++++++++++++++++++++++
 tb/tb_control_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the Mini-SRC CPU.
//
// Sequences fetch (T0-T2), opcode decode in T3, per-class execute steps (T3-T7), then returns
// to fetch. Every datapath strobe is a decode of the current state, with the IR opcode used
// from T3 onward and CON used in T6 of br.
//
// Ports:
//   clock             system clock, rising edge
//   clear             synchronous active-high reset (forces RST from any state)
//   IR                current instruction, opcode in IR[31:27]
//   CON               branch condition from con_ff
//   stop              pause request, sampled only on the edge that would enter T0
//   Run               1 while sequencing (T0-T7), 0 in RST/PAUSE/HALT
//   PCout ... OutPortin  datapath, ALU, register-select and I/O strobes
module control_unit #(
  parameter int unsigned OP_W = 5,
  parameter int unsigned IR_W = 32
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [IR_W-1:0] IR,
  input  logic            CON,
  input  logic            stop,
  output logic            Run,
  output logic            PCout,
  output logic            IncPC,
  output logic            PCin,
  output logic            MARin,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            Read,
  output logic            Write,
  output logic            Zlowin,
  output logic            Zhighin,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            HIin,
  output logic            LOin,
  output logic            HIout,
  output logic            LOout,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic            Cout,
  output logic            CONin,
  output logic            JAL_flag,
  output logic            InPortout,
  output logic            OutPortin
);

  typedef enum logic [3:0] {
    StRst, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StPause, StHalt
  } state_e;

  // Instruction classes sharing one execute sequence.
  typedef enum logic [3:0] {
    ClsAlu, ClsImm, ClsLdi, ClsLd, ClsSt, ClsMulDiv, ClsNegNot, ClsBr,
    ClsJr, ClsJal, ClsIn, ClsOut, ClsMfhi, ClsMflo, ClsNop, ClsHalt
  } cls_e;

  state_e          state_q;
  state_e          last_step;
  state_e          fetch_entry;
  cls_e            cls;
  logic [OP_W-1:0] opcode;
  logic            unused_ir;

  assign opcode    = IR[IR_W-1 -: OP_W];
  assign unused_ir = ^IR[IR_W-OP_W-1:0];

  always_comb begin
    cls = ClsNop;
    case (opcode)
      5'd0:                                               cls = ClsLd;
      5'd1:                                               cls = ClsLdi;
      5'd2:                                               cls = ClsSt;
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: cls = ClsAlu;
      5'd12, 5'd13, 5'd14:                                cls = ClsImm;
      5'd15, 5'd16:                                       cls = ClsMulDiv;
      5'd17, 5'd18:                                       cls = ClsNegNot;
      5'd19:                                              cls = ClsBr;
      5'd20:                                              cls = ClsJr;
      5'd21:                                              cls = ClsJal;
      5'd22:                                              cls = ClsIn;
      5'd23:                                              cls = ClsOut;
      5'd24:                                              cls = ClsMfhi;
      5'd25:                                              cls = ClsMflo;
      5'd27:                                              cls = ClsHalt;
      default:                                            cls = ClsNop;
    endcase
  end

  // Final execute step of each class; the edge leaving it goes back to fetch.
  always_comb begin
    last_step = StT3;
    case (cls)
      ClsAlu, ClsImm, ClsLdi: last_step = StT5;
      ClsLd, ClsSt:           last_step = StT7;
      ClsMulDiv, ClsBr:       last_step = StT6;
      ClsNegNot, ClsJal:      last_step = StT4;
      default:                last_step = StT3;
    endcase
  end

  // stop only diverts the return to fetch, so an instruction is never truncated.
  assign fetch_entry = stop ? StPause : StT0;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= StRst;
    end else begin
      case (state_q)
        StRst:   state_q <= StT0;
        StT0:    state_q <= StT1;
        StT1:    state_q <= StT2;
        StT2:    state_q <= StT3;
        StT3: begin
          if (cls == ClsHalt)          state_q <= StHalt;
          else if (last_step == StT3)  state_q <= fetch_entry;
          else                         state_q <= StT4;
        end
        StT4:    state_q <= (last_step == StT4) ? fetch_entry : StT5;
        StT5:    state_q <= (last_step == StT5) ? fetch_entry : StT6;
        StT6:    state_q <= (last_step == StT6) ? fetch_entry : StT7;
        StT7:    state_q <= fetch_entry;
        StPause: state_q <= stop ? StPause : StT0;
        StHalt:  state_q <= StHalt;
        default: state_q <= StRst;
      endcase
    end
  end

  always_comb begin
    Run       = 1'b0;
    PCout     = 1'b0;
    IncPC     = 1'b0;
    PCin      = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Read      = 1'b0;
    Write     = 1'b0;
    Zlowin    = 1'b0;
    Zhighin   = 1'b0;
    Zlowout   = 1'b0;
    Zhighout  = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    HIout     = 1'b0;
    LOout     = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    Rin       = 1'b0;
    Rout      = 1'b0;
    BAout     = 1'b0;
    Cout      = 1'b0;
    CONin     = 1'b0;
    JAL_flag  = 1'b0;
    InPortout = 1'b0;
    OutPortin = 1'b0;

    case (state_q)
      StT0: begin
        Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
      end
      StT1: begin
        Run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      StT2: begin
        Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
      end
      StT3: begin
        Run = 1'b1;
        case (cls)
          ClsAlu, ClsImm:      begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          ClsLdi, ClsLd, ClsSt: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          ClsMulDiv:           begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          ClsNegNot:           begin Grb = 1'b1; Rout = 1'b1; Zlowin = 1'b1; end
          ClsBr:               begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          ClsJr:               begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          ClsJal:              begin PCout = 1'b1; JAL_flag = 1'b1; end
          ClsIn:               begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsOut:              begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
          ClsMfhi:             begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsMflo:             begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default:             ;
        endcase
      end
      StT4: begin
        Run = 1'b1;
        case (cls)
          ClsAlu:                       begin Grc = 1'b1; Rout = 1'b1; Zlowin = 1'b1; end
          ClsImm, ClsLdi, ClsLd, ClsSt: begin Cout = 1'b1; Zlowin = 1'b1; end
          ClsMulDiv: begin
            Grb = 1'b1; Rout = 1'b1; Zlowin = 1'b1; Zhighin = 1'b1;
          end
          ClsNegNot:                    begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsBr:                        begin PCout = 1'b1; Yin = 1'b1; end
          ClsJal:                       begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          default:                      ;
        endcase
      end
      StT5: begin
        Run = 1'b1;
        case (cls)
          ClsAlu, ClsImm, ClsLdi: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsLd, ClsSt:           begin Zlowout = 1'b1; MARin = 1'b1; end
          ClsMulDiv:              begin Zlowout = 1'b1; LOin = 1'b1; end
          ClsBr:                  begin Cout = 1'b1; Zlowin = 1'b1; end
          default:                ;
        endcase
      end
      StT6: begin
        Run = 1'b1;
        case (cls)
          ClsLd:     begin Read = 1'b1; MDRin = 1'b1; end
          ClsSt:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          ClsMulDiv: begin Zhighout = 1'b1; HIin = 1'b1; end
          ClsBr:     begin Zlowout = 1'b1; PCin = CON; end
          default:   ;
        endcase
      end
      StT7: begin
        Run = 1'b1;
        case (cls)
          ClsLd:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsSt:   Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the stimulus process pushes the expected output vector of
// every cycle it drives, and a negedge monitor pops and compares against the DUT outputs.
module tb_control_unit;

  // Expected-vector bit positions.
  localparam logic [29:0] PCOUT  = 30'd1 << 0;
  localparam logic [29:0] INCPC  = 30'd1 << 1;
  localparam logic [29:0] PCIN   = 30'd1 << 2;
  localparam logic [29:0] MARIN  = 30'd1 << 3;
  localparam logic [29:0] MDRIN  = 30'd1 << 4;
  localparam logic [29:0] MDROUT = 30'd1 << 5;
  localparam logic [29:0] IRIN   = 30'd1 << 6;
  localparam logic [29:0] YIN    = 30'd1 << 7;
  localparam logic [29:0] READ   = 30'd1 << 8;
  localparam logic [29:0] WRITE  = 30'd1 << 9;
  localparam logic [29:0] ZLIN   = 30'd1 << 10;
  localparam logic [29:0] ZHIN   = 30'd1 << 11;
  localparam logic [29:0] ZLOUT  = 30'd1 << 12;
  localparam logic [29:0] ZHOUT  = 30'd1 << 13;
  localparam logic [29:0] HIIN   = 30'd1 << 14;
  localparam logic [29:0] LOIN   = 30'd1 << 15;
  localparam logic [29:0] HIOUT  = 30'd1 << 16;
  localparam logic [29:0] LOOUT  = 30'd1 << 17;
  localparam logic [29:0] GRA    = 30'd1 << 18;
  localparam logic [29:0] GRB    = 30'd1 << 19;
  localparam logic [29:0] GRC    = 30'd1 << 20;
  localparam logic [29:0] RIN    = 30'd1 << 21;
  localparam logic [29:0] ROUT   = 30'd1 << 22;
  localparam logic [29:0] BAOUT  = 30'd1 << 23;
  localparam logic [29:0] COUT   = 30'd1 << 24;
  localparam logic [29:0] CONIN  = 30'd1 << 25;
  localparam logic [29:0] JAL    = 30'd1 << 26;
  localparam logic [29:0] INP    = 30'd1 << 27;
  localparam logic [29:0] OUTP   = 30'd1 << 28;
  localparam logic [29:0] RUN    = 30'd1 << 29;

  logic        clock, clear, CON, stop;
  logic [31:0] IR;
  logic Run, PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, Yin, Read, Write;
  logic Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, HIout, LOout;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, JAL_flag, InPortout, OutPortin;
  logic [29:0] act;

  control_unit #(.OP_W(5), .IR_W(32)) dut (
    .clock(clock), .clear(clear), .IR(IR), .CON(CON), .stop(stop), .Run(Run),
    .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Read(Read), .Write(Write),
    .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .CONin(CONin), .JAL_flag(JAL_flag), .InPortout(InPortout), .OutPortin(OutPortin)
  );

  assign act = {Run, OutPortin, InPortout, JAL_flag, CONin, Cout, BAout, Rout, Rin, Grc, Grb,
                Gra, LOout, HIout, LOin, HIin, Zhighout, Zlowout, Zhighin, Zlowin, Write, Read,
                Yin, IRin, MDRout, MDRin, MARin, PCin, IncPC, PCout};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [29:0] vec;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [29:0] steps[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          instr_no = 0;

  // Monitor: one scoreboard entry per driven cycle, checked mid-cycle.
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (act !== e.vec) begin
        miscompares++;
        $display("FAIL %s: got %h, expected %h", e.tag, act, e.vec);
      end
    end
  end

  // Reference sequence of one instruction: fetch then the execute steps of its class.
  function automatic void build(input logic [31:0] ir, input logic con);
    int op;
    op = int'(ir[31:27]);
    steps.delete();
    steps.push_back(RUN | PCOUT | MARIN | INCPC | ZLIN);
    steps.push_back(RUN | ZLOUT | PCIN | READ | MDRIN);
    steps.push_back(RUN | MDROUT | IRIN);
    if (op >= 3 && op <= 11) begin
      steps.push_back(RUN | GRB | ROUT | YIN);
      steps.push_back(RUN | GRC | ROUT | ZLIN);
      steps.push_back(RUN | ZLOUT | GRA | RIN);
    end else if (op >= 12 && op <= 14) begin
      steps.push_back(RUN | GRB | ROUT | YIN);
      steps.push_back(RUN | COUT | ZLIN);
      steps.push_back(RUN | ZLOUT | GRA | RIN);
    end else if (op == 1) begin
      steps.push_back(RUN | GRB | BAOUT | YIN);
      steps.push_back(RUN | COUT | ZLIN);
      steps.push_back(RUN | ZLOUT | GRA | RIN);
    end else if (op == 0 || op == 2) begin
      steps.push_back(RUN | GRB | BAOUT | YIN);
      steps.push_back(RUN | COUT | ZLIN);
      steps.push_back(RUN | ZLOUT | MARIN);
      if (op == 0) begin
        steps.push_back(RUN | READ | MDRIN);
        steps.push_back(RUN | MDROUT | GRA | RIN);
      end else begin
        steps.push_back(RUN | GRA | ROUT | MDRIN);
        steps.push_back(RUN | WRITE);
      end
    end else if (op == 15 || op == 16) begin
      steps.push_back(RUN | GRA | ROUT | YIN);
      steps.push_back(RUN | GRB | ROUT | ZLIN | ZHIN);
      steps.push_back(RUN | ZLOUT | LOIN);
      steps.push_back(RUN | ZHOUT | HIIN);
    end else if (op == 17 || op == 18) begin
      steps.push_back(RUN | GRB | ROUT | ZLIN);
      steps.push_back(RUN | ZLOUT | GRA | RIN);
    end else if (op == 19) begin
      steps.push_back(RUN | GRA | ROUT | CONIN);
      steps.push_back(RUN | PCOUT | YIN);
      steps.push_back(RUN | COUT | ZLIN);
      steps.push_back(RUN | ZLOUT | (con ? PCIN : 30'd0));
    end else if (op == 20) begin
      steps.push_back(RUN | GRA | ROUT | PCIN);
    end else if (op == 21) begin
      steps.push_back(RUN | PCOUT | JAL);
      steps.push_back(RUN | GRA | ROUT | PCIN);
    end else if (op == 22) steps.push_back(RUN | INP | GRA | RIN);
    else if (op == 23) steps.push_back(RUN | GRA | ROUT | OUTP);
    else if (op == 24) steps.push_back(RUN | HIOUT | GRA | RIN);
    else if (op == 25) steps.push_back(RUN | LOOUT | GRA | RIN);
    else steps.push_back(RUN);  // nop, halt's T3, undefined
  endfunction

  // One driven cycle: inputs already set, expectation queued, then the ending edge.
  task automatic cyc(input logic [29:0] v, input string tag);
    exp_t e;
    e.vec = v;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  // pause_len > 0 holds stop across the final step and keeps PAUSE for that many cycles.
  // abort_at >= 0 raises clear for two cycles starting at that step index.
  task automatic run_instr(input logic [31:0] ir, input logic con, input int pause_len,
                           input int abort_at);
    int n;
    instr_no++;
    build(ir, con);
    n = steps.size();
    for (int i = 0; i < n; i++) begin
      // IR is only meaningful from T3; feed garbage during fetch.
      IR   = (i < 3) ? $urandom : ir;
      CON  = con;
      stop = (i == n - 1) ? (pause_len > 0) : 1'($urandom_range(0, 1));
      if (i == abort_at) begin
        clear = 1'b1;
        cyc(steps[i], $sformatf("i%0d op%0d step%0d clear", instr_no, ir[31:27], i));
        stop = 1'b0;
        cyc(30'd0, $sformatf("i%0d held-clear", instr_no));
        clear = 1'b0;
        cyc(30'd0, $sformatf("i%0d released-clear", instr_no));
        return;
      end
      cyc(steps[i], $sformatf("i%0d op%0d step%0d", instr_no, ir[31:27], i));
    end
    for (int k = 1; k <= pause_len; k++) begin
      stop = (k < pause_len);
      cyc(30'd0, $sformatf("i%0d pause%0d", instr_no, k));
    end
    stop = 1'b0;
  endtask

  task automatic run_halt(input logic [31:0] ir);
    instr_no++;
    build(ir, 1'b0);
    for (int i = 0; i < steps.size(); i++) begin
      IR   = (i < 3) ? $urandom : ir;
      stop = 1'($urandom_range(0, 1));
      cyc(steps[i], $sformatf("i%0d halt step%0d", instr_no, i));
    end
    for (int k = 0; k < 20; k++) begin
      stop = k[0];
      cyc(30'd0, $sformatf("i%0d halted%0d", instr_no, k));
    end
    clear = 1'b1;
    stop  = 1'b0;
    cyc(30'd0, "halt-clear");
    clear = 1'b0;
    cyc(30'd0, "halt-rst");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ir;
    int          op;
    clear = 1'b1;
    stop  = 1'b0;
    CON   = 1'b0;
    IR    = 32'h0;
    @(posedge clock);
    #1;
    cyc(30'd0, "reset-held");
    clear = 1'b0;
    cyc(30'd0, "reset-release");

    run_instr(32'h19890000, 1'b0, 0, -1);  // add
    run_instr(32'h19890000, 1'b0, 0, 4);   // add cleared mid-T4
    run_instr(32'h19890000, 1'b1, 0, -1);
    run_instr(32'h01080055, 1'b0, 0, -1);  // ld
    run_instr(32'h11000063, 1'b1, 0, -1);  // st
    run_instr(32'h98000000, 1'b1, 0, -1);  // br taken
    run_instr(32'h98000000, 1'b0, 0, -1);  // br not taken
    run_instr(32'hA8000000, 1'b0, 0, -1);  // jal
    run_instr(32'h19890000, 1'b0, 3, -1);  // add with stop into PAUSE
    run_instr(32'hD0000000, 1'b1, 1, -1);  // nop with one pause cycle

    for (int t = 0; t < 150; t++) begin
      do op = $urandom_range(0, 31); while (op == 27);
      ir = {op[4:0], 27'($urandom)};
      run_instr(ir, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0, -1);
    end

    run_halt(32'hD8000000);
    run_instr(32'h19890000, 1'b0, 0, -1);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clock);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
